clk_lock_rst_seq: RTL



---
 rtl/clk_rst_pkg.sv | 33 +++
 rtl/lock_sync.sv | 25 ++
 rtl/clk_lock_rst_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/clk_rst_pkg.sv
// Shared state encoding, default sizing and a constant-width helper for the lock/reset sequencer.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    RST_MMCM  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam int DEF_N_LOCK           = 3;
  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_MMCM_RST_CYC     = 8;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_STAGE_GAP_CYC    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 1000000;
  localparam int DEF_CNT_W            = 8;

  // Bits needed to hold 0..value-1; never narrower than one bit.
  function automatic int clog2_f(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchronizer for the asynchronous MMCM locked flags.
// Latency STAGES cycles, no backpressure; clears to 0 on reset.
module lock_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_lock_rst_seq.sv
// Sequences MMCM reset, waits for stable lock, then releases per-domain resets in order.
// All outputs registered; lock loss drops every domain on the next edge and re-arms without an MMCM reset.
module clk_lock_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int N_LOCK           = DEF_N_LOCK,
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int MMCM_RST_CYC     = DEF_MMCM_RST_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int STAGE_GAP_CYC    = DEF_STAGE_GAP_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_LOCK-1:0] locked_in,
  input  logic              soft_rst_req,
  output logic              mmcm_rst,
  output logic [N_LOCK-1:0] stage_rstn,
  output logic              all_ready,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  lock_loss_cnt,
  output logic              timeout_flag
);

  localparam int MAX_AB  = (MMCM_RST_CYC > LOCK_STABLE_CYC) ? MMCM_RST_CYC : LOCK_STABLE_CYC;
  localparam int MAX_CD  = (STAGE_GAP_CYC > LOCK_TIMEOUT_CYC) ? STAGE_GAP_CYC : LOCK_TIMEOUT_CYC;
  localparam int CW      = clog2_f((MAX_AB > MAX_CD) ? MAX_AB : MAX_CD);
  localparam int IW      = clog2_f(N_LOCK);

  localparam logic [CW-1:0]     RST_LAST = CW'(MMCM_RST_CYC - 1);
  localparam logic [CW-1:0]     STB_LAST = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0]     GAP_LAST = CW'(STAGE_GAP_CYC - 1);
  localparam logic [CW-1:0]     TMO_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [IW-1:0]     PEN_IDX  = IW'(N_LOCK - 2);
  localparam logic [N_LOCK-1:0] ONE      = N_LOCK'(1);

  logic [N_LOCK-1:0] lk_s;
  logic              all_lk;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              mmcm_rst_q, mmcm_rst_d;
  logic [N_LOCK-1:0] stage_q, stage_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  loss_q, loss_d;
  logic              tmo_q, tmo_d;

  lock_sync #(
    .WIDTH  (N_LOCK),
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .rstn    (rstn),
    .async_i (locked_in),
    .sync_o  (lk_s)
  );

  assign all_lk = &lk_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RST_MMCM;
      cnt_q      <= '0;
      idx_q      <= '0;
      mmcm_rst_q <= 1'b1;
      stage_q    <= '0;
      ready_q    <= 1'b0;
      loss_q     <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      mmcm_rst_q <= mmcm_rst_d;
      stage_q    <= stage_d;
      ready_q    <= ready_d;
      loss_q     <= loss_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST_MMCM:  if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (all_lk)                 state_d = STABLE;
        else if (cnt_q == TMO_LAST) state_d = RST_MMCM;
      end
      STABLE: begin
        if (!all_lk)                state_d = WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = RELEASE;
      end
      RELEASE: begin
        if (!all_lk)                                     state_d = WAIT_LOCK;
        else if (cnt_q == GAP_LAST && idx_q == PEN_IDX)  state_d = RUN;
      end
      RUN:     if (!all_lk) state_d = WAIT_LOCK;
      default: state_d = RST_MMCM;
    endcase
    // Restart outranks lock loss, so loss is never counted on a restart cycle.
    if (soft_rst_req && state_q != RST_MMCM) state_d = RST_MMCM;
  end

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stage_d    = stage_q;
    loss_d     = loss_q;
    tmo_d      = tmo_q;
    mmcm_rst_d = (state_d == RST_MMCM);
    ready_d    = (state_d == RUN);

    if (state_d != state_q || (state_q == RELEASE && cnt_q == GAP_LAST)) cnt_d = '0;
    else if (state_q != RUN)                                            cnt_d = cnt_q + CW'(1);

    if (state_d == RST_MMCM || state_d == WAIT_LOCK) begin
      stage_d = '0;
    end else if (state_q == STABLE && state_d == RELEASE) begin
      stage_d = ONE;
      idx_d   = '0;
    end else if (state_q == RELEASE && cnt_q == GAP_LAST) begin
      stage_d = stage_q | (ONE << (idx_q + IW'(1)));
      idx_d   = idx_q + IW'(1);
    end

    if ((state_q == RELEASE || state_q == RUN) && state_d == WAIT_LOCK && loss_q != '1)
      loss_d = loss_q + CNT_W'(1);

    if (state_q == WAIT_LOCK && !all_lk && cnt_q == TMO_LAST) tmo_d = 1'b1;
  end

  assign mmcm_rst      = mmcm_rst_q;
  assign stage_rstn    = stage_q;
  assign all_ready     = ready_q;
  assign state_o       = state_q;
  assign lock_loss_cnt = loss_q;
  assign timeout_flag  = tmo_q;

endmodule
